// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU operation codes, decoded control bundle.
package cpu_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 3;

  // Opcodes, instruction bits [31:26]
  localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB  = 6'b000001;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b010000;
  localparam logic [OP_W-1:0] OP_AND  = 6'b010001;
  localparam logic [OP_W-1:0] OP_OR   = 6'b010010;
  localparam logic [OP_W-1:0] OP_MOVE = 6'b100000;
  localparam logic [OP_W-1:0] OP_SW   = 6'b100110;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100111;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b110000;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  // ALU operation codes
  localparam logic [ALUOP_W-1:0] ALU_ADD  = 3'b000;  // A+B
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 3'b001;  // A-B
  localparam logic [ALUOP_W-1:0] ALU_RSUB = 3'b010;  // B-A
  localparam logic [ALUOP_W-1:0] ALU_OR   = 3'b011;  // A|B
  localparam logic [ALUOP_W-1:0] ALU_AND  = 3'b100;  // A&B
  localparam logic [ALUOP_W-1:0] ALU_ANDN = 3'b101;  // ~A&B
  localparam logic [ALUOP_W-1:0] ALU_XOR  = 3'b110;  // A^B
  localparam logic [ALUOP_W-1:0] ALU_XNOR = 3'b111;  // ~(A^B)

  // Raw decode result before reset/halt gating
  typedef struct packed {
    logic                regOut;
    logic                extSel;
    logic                dataMenRW;
    logic                aluM2Reg;
    logic                aluSrcB;
    logic                pcSrc;
    logic                regWre;
    logic                pcWre;
    logic [ALUOP_W-1:0]  aluOp;
  } ctrl_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } haltState_t;

endpackage

// File: rtl/control_unit.sv
// Control unit of the single-cycle MIPS-subset CPU.
// Decodes op (and zero for beq) into datapath controls; a sticky halted
// state blocks PC/register/memory writes until Reset.
// Ports:
//   CLK, Reset (async, active-low)
//   op[5:0], zero                          - opcode and ALU zero flag
//   RegOut, InsMenRW, ExtSel, DataMenRW,
//   ALUM2Reg, ALUSrcB, PCSrc, RegWre,
//   PCWre, ALUOp[2:0]                      - combinational control outputs
module control_unit
  import cpu_pkg::*;
(
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  output logic               RegOut,
  output logic               InsMenRW,
  output logic               ExtSel,
  output logic               DataMenRW,
  output logic               ALUM2Reg,
  output logic               ALUSrcB,
  output logic               PCSrc,
  output logic               RegWre,
  output logic               PCWre,
  output logic [ALUOP_W-1:0] ALUOp
);

  haltState_t state;
  haltState_t stateNext;
  ctrl_t      dec;

  // Halted flag register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= ST_RUN;
    else        state <= stateNext;
  end

  // Halt is entered on any edge that sees the halt opcode; only Reset leaves it
  always_comb begin
    stateNext = state;
    if (op == OP_HALT) stateNext = ST_HALTED;
  end

  // Opcode decode; unknown opcodes fall through as NOP
  always_comb begin
    dec       = '0;
    dec.pcWre = 1'b1;
    dec.aluOp = ALU_ADD;
    case (op)
      OP_ADD, OP_MOVE: begin
        dec.regOut = 1'b1;
        dec.regWre = 1'b1;
      end
      OP_SUB: begin
        dec.regOut = 1'b1;
        dec.regWre = 1'b1;
        dec.aluOp  = ALU_SUB;
      end
      OP_ORI: begin
        dec.aluSrcB = 1'b1;
        dec.regWre  = 1'b1;
        dec.aluOp   = ALU_OR;
      end
      OP_AND: begin
        dec.regOut = 1'b1;
        dec.regWre = 1'b1;
        dec.aluOp  = ALU_AND;
      end
      OP_OR: begin
        dec.regOut = 1'b1;
        dec.regWre = 1'b1;
        dec.aluOp  = ALU_OR;
      end
      OP_SW: begin
        dec.aluSrcB   = 1'b1;
        dec.extSel    = 1'b1;
        dec.dataMenRW = 1'b1;
      end
      OP_LW: begin
        dec.aluSrcB  = 1'b1;
        dec.extSel   = 1'b1;
        dec.aluM2Reg = 1'b1;
        dec.regWre   = 1'b1;
      end
      OP_BEQ: begin
        dec.extSel = 1'b1;
        dec.aluOp  = ALU_SUB;
        dec.pcSrc  = zero;
      end
      OP_HALT: begin
        dec.pcWre = 1'b0;
      end
      default: ;
    endcase
  end

  // Output gating: reset and halted state suppress all write enables
  always_comb begin
    RegOut    = dec.regOut;
    ExtSel    = dec.extSel;
    ALUM2Reg  = dec.aluM2Reg;
    ALUSrcB   = dec.aluSrcB;
    PCSrc     = dec.pcSrc;
    ALUOp     = dec.aluOp;
    InsMenRW  = Reset;
    PCWre     = dec.pcWre;
    RegWre    = dec.regWre;
    DataMenRW = dec.dataMenRW;
    if (!Reset || state == ST_HALTED) begin
      PCWre     = 1'b0;
      RegWre    = 1'b0;
      DataMenRW = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with an expected-value scoreboard.
// Expected vector layout: {RegOut, InsMenRW, ExtSel, DataMenRW, ALUM2Reg,
//                          ALUSrcB, PCSrc, RegWre, PCWre, ALUOp[2:0]}
module tb_control_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] op;
  logic       zero;
  logic       RegOut, InsMenRW, ExtSel, DataMenRW, ALUM2Reg;
  logic       ALUSrcB, PCSrc, RegWre, PCWre;
  logic [2:0] ALUOp;

  typedef struct {
    string      tag;
    logic [11:0] exp;
  } sbEntry_t;

  sbEntry_t sb[$];
  int total = 0;
  int bad   = 0;

  control_unit dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .op        (op),
    .zero      (zero),
    .RegOut    (RegOut),
    .InsMenRW  (InsMenRW),
    .ExtSel    (ExtSel),
    .DataMenRW (DataMenRW),
    .ALUM2Reg  (ALUM2Reg),
    .ALUSrcB   (ALUSrcB),
    .PCSrc     (PCSrc),
    .RegWre    (RegWre),
    .PCWre     (PCWre),
    .ALUOp     (ALUOp)
  );

  always #5 CLK = ~CLK;

  // Run-length guard
  initial begin
    #20000;
    $display("FAIL watchdog: test did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] observed();
    return {RegOut, InsMenRW, ExtSel, DataMenRW, ALUM2Reg,
            ALUSrcB, PCSrc, RegWre, PCWre, ALUOp};
  endfunction

  // Pop the oldest expectation and compare against the live outputs
  task automatic checkOut();
    sbEntry_t e;
    logic [11:0] obs;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty obs=none exp=entry");
      return;
    end
    e   = sb.pop_front();
    obs = observed();
    total++;
    assert (obs === e.exp)
      else begin
        bad++;
        $error("FAIL %s obs=%b exp=%b", e.tag, obs, e.exp);
      end
  endtask

  // Drive one input set away from the rising edge, then check after settling
  task automatic step(input logic rst, input logic [5:0] o, input logic z,
                      input string tag, input logic [11:0] e);
    sbEntry_t s;
    @(negedge CLK);
    Reset = rst;
    op    = o;
    zero  = z;
    s.tag = tag;
    s.exp = e;
    sb.push_back(s);
    #1;
    checkOut();
  endtask

  initial begin
    sbEntry_t s;
    Reset = 1'b0;
    op    = 6'b000000;
    zero  = 1'b0;

    // Reset held: write enables and InsMenRW forced low
    step(1'b0, 6'b000000, 1'b0, "reset_add",  12'b1_0_0_0_0_0_0_0_0_000);
    step(1'b0, 6'b000000, 1'b0, "reset_hold", 12'b1_0_0_0_0_0_0_0_0_000);
    // Release
    step(1'b1, 6'b000000, 1'b0, "add",   12'b1_1_0_0_0_0_0_1_1_000);
    step(1'b1, 6'b000001, 1'b0, "sub",   12'b1_1_0_0_0_0_0_1_1_001);
    step(1'b1, 6'b010000, 1'b0, "ori",   12'b0_1_0_0_0_1_0_1_1_011);
    step(1'b1, 6'b010001, 1'b0, "and",   12'b1_1_0_0_0_0_0_1_1_100);
    step(1'b1, 6'b010010, 1'b0, "or",    12'b1_1_0_0_0_0_0_1_1_011);
    step(1'b1, 6'b100000, 1'b0, "move",  12'b1_1_0_0_0_0_0_1_1_000);
    step(1'b1, 6'b100110, 1'b0, "sw",    12'b0_1_1_1_0_1_0_0_1_000);
    step(1'b1, 6'b100111, 1'b0, "lw",    12'b0_1_1_0_1_1_0_1_1_000);
    // beq with zero toggling 0 -> 1 -> 0
    step(1'b1, 6'b110000, 1'b0, "beq_z0",  12'b0_1_1_0_0_0_0_0_1_001);
    step(1'b1, 6'b110000, 1'b1, "beq_z1",  12'b0_1_1_0_0_0_1_0_1_001);
    step(1'b1, 6'b110000, 1'b0, "beq_z0b", 12'b0_1_1_0_0_0_0_0_1_001);
    // Undefined opcode behaves as NOP; zero must not leak into PCSrc
    step(1'b1, 6'b101010, 1'b1, "nop_101010", 12'b0_1_0_0_0_0_0_0_1_000);
    step(1'b1, 6'b001111, 1'b0, "nop_001111", 12'b0_1_0_0_0_0_0_0_1_000);
    // Halt: immediate effect, then sticky after the next rising edge
    step(1'b1, 6'b111111, 1'b0, "halt_now",    12'b0_1_0_0_0_0_0_0_0_000);
    step(1'b1, 6'b000000, 1'b0, "halted_add",  12'b1_1_0_0_0_0_0_0_0_000);
    step(1'b1, 6'b100110, 1'b0, "halted_sw",   12'b0_1_1_0_0_1_0_0_0_000);
    step(1'b1, 6'b110000, 1'b1, "halted_beq",  12'b0_1_1_0_0_0_1_0_0_001);
    step(1'b1, 6'b100111, 1'b0, "halted_lw",   12'b0_1_1_0_1_1_0_0_0_000);
    // Reset pulse wholly between rising edges must clear the flag asynchronously
    step(1'b0, 6'b000000, 1'b0, "halt_reset",  12'b1_0_0_0_0_0_0_0_0_000);
    #2;
    Reset = 1'b1;
    s.tag = "async_clear";
    s.exp = 12'b1_1_0_0_0_0_0_1_1_000;
    sb.push_back(s);
    #1;
    checkOut();
    step(1'b1, 6'b000000, 1'b0, "resume_add", 12'b1_1_0_0_0_0_0_1_1_000);
    // Halt presented while in reset: no flag set, outputs resume on release
    step(1'b0, 6'b111111, 1'b0, "reset_halt_op", 12'b0_0_0_0_0_0_0_0_0_000);
    step(1'b1, 6'b000001, 1'b0, "post_reset_sub", 12'b1_1_0_0_0_0_0_1_1_001);
    // Halt again, then Reset held across an edge, then release
    step(1'b1, 6'b111111, 1'b0, "halt2_now",   12'b0_1_0_0_0_0_0_0_0_000);
    step(1'b1, 6'b010001, 1'b0, "halted2_and", 12'b1_1_0_0_0_0_0_0_0_100);
    step(1'b0, 6'b010001, 1'b0, "reset2_and",  12'b1_0_0_0_0_0_0_0_0_100);
    step(1'b1, 6'b010001, 1'b0, "resume2_and", 12'b1_1_0_0_0_0_0_1_1_100);

    total++;
    assert (sb.size() == 0)
      else begin
        bad++;
        $error("FAIL scoreboard_drain obs=%0d exp=0", sb.size());
      end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
